dmem_misalign_seq: RTL and testbench

- Sits between the EX/MEM pipeline register and the data-memory controller, in the MEM stage.
- Aligned loads and stores pass through unchanged.
- Misaligned halfword/word accesses are split into sequential single-byte accesses (SB stores / LBU loads) issued to the controller. The pipeline is stalled meanwhile.
- For loads, the returned bytes are assembled and sign- or zero-extended into one result for writeback.

---
 rtl/dmem_misalign_seq_pkg.sv | 23 ++
 rtl/dmem_misalign_seq.sv | 149 ++++++++++++++
 tb/tb_dmem_misalign_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_misalign_seq_pkg.sv
// Shared definitions for the MEM-stage misaligned access sequencer and the DMEM controller.
package dmem_misalign_seq_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

  function automatic logic [31:0] ld_extend(input logic [2:0] funct3, input logic [31:0] raw);
    case (funct3)
      LH:      return {{16{raw[15]}}, raw[15:0]};
      LHU:     return {16'h0000, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_misalign_seq.sv
// Splits misaligned LH/LHU/LW/SH/SW into byte accesses and reassembles load data.
// Define MISALIGN_TRAP_EN to suppress misaligned accesses and only flag them.
module dmem_misalign_seq
  import dmem_misalign_seq_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  in_funct3,
  input  logic [15:0] in_byte_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_read,
  input  logic        in_write,
  output logic [2:0]  out_funct3,
  output logic [15:0] out_byte_addr,
  output logic [31:0] out_wdata,
  output logic        out_read,
  output logic        out_write,
  input  logic [31:0] ctl_rdata,
  output logic        stall_o,
  output logic        ld_sel,
  output logic [31:0] ld_data,
  output logic        misalign_o
);

  localparam logic [2:0] LAT3 = 3'(RD_LAT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d, ld_q;
  logic        is_store, is_load, mis, issue;
  logic [2:0]  nbytes, last_cyc, cyc, cap_idx;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^ctl_rdata[31:8];

  always_comb begin
    is_store = in_write;
    is_load  = in_read & ~in_write;
    nbytes   = 3'd1;
    if (in_funct3 == LH || (is_load && in_funct3 == LHU)) nbytes = 3'd2;
    else if (in_funct3 == LW)                              nbytes = 3'd4;
    mis = (is_store | is_load) &&
          ((nbytes == 3'd2 && in_byte_addr[0]) ||
           (nbytes == 3'd4 && in_byte_addr[1:0] != 2'b00));
    last_cyc = nbytes + (is_load ? LAT3 : 3'd0) - 3'd1;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    asm_d         = asm_q;
    out_funct3    = '0;
    out_byte_addr = '0;
    out_wdata     = '0;
    out_read      = 1'b0;
    out_write     = 1'b0;
    stall_o       = 1'b0;
    ld_sel        = 1'b0;
    misalign_o    = 1'b0;
    issue         = 1'b0;
    cyc           = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        cyc   = '0;
        if (!mis) begin
          out_funct3    = in_funct3;
          out_byte_addr = in_byte_addr;
          out_wdata     = in_wdata;
          out_read      = in_read;
          out_write     = in_write;
        end else begin
`ifdef MISALIGN_TRAP_EN
          out_funct3    = in_funct3;
          out_byte_addr = in_byte_addr;
          out_wdata     = in_wdata;
          misalign_o    = 1'b1;
`else
          misalign_o = 1'b1;
          stall_o    = 1'b1;
          issue      = 1'b1;
          asm_d      = '0;
          cnt_d      = 3'd1;
          state_d    = SPLIT;
`endif
        end
      end
      SPLIT: begin
        stall_o = 1'b1;
        issue   = (cnt_q < nbytes);
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == last_cyc) state_d = DONE;
      end
      DONE: begin
        ld_sel  = is_load;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // cyc is the split cycle index: byte cyc is issued, byte cyc-RD_LAT is captured.
    if (issue) begin
      out_byte_addr = in_byte_addr + {13'd0, cyc};
      if (is_store) begin
        out_funct3 = SB;
        out_write  = 1'b1;
        out_wdata  = {24'd0, in_wdata[{cyc[1:0], 3'b000} +: 8]};
      end else begin
        out_funct3 = LBU;
        out_read   = 1'b1;
      end
    end

    cap_idx = cyc - LAT3;
    if (is_load && stall_o && cyc >= LAT3 && cap_idx < nbytes)
      asm_d[{cap_idx[1:0], 3'b000} +: 8] = ctl_rdata[7:0];

    if (rst) begin
      out_read   = 1'b0;
      out_write  = 1'b0;
      stall_o    = 1'b0;
      misalign_o = 1'b0;
      ld_sel     = 1'b0;
    end
  end

  always_comb begin
    ld_data = ld_q;
    if (state_q == DONE && is_load) ld_data = ld_extend(in_funct3, asm_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      if (ld_sel) ld_q <= ld_data;
    end
  end

endmodule

// File: tb/tb_dmem_misalign_seq.sv
// Directed bench for dmem_misalign_seq with a byte-memory controller model and per-cycle scoreboard.
module tb_dmem_misalign_seq;
  import dmem_misalign_seq_pkg::*;

  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_funct3;
  logic [15:0] in_byte_addr;
  logic [31:0] in_wdata;
  logic        in_read, in_write;
  logic [2:0]  out_funct3;
  logic [15:0] out_byte_addr;
  logic [31:0] out_wdata;
  logic        out_read, out_write;
  logic [31:0] ctl_rdata;
  logic        stall_o, ld_sel, misalign_o;
  logic [31:0] ld_data;

  dmem_misalign_seq #(.RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_funct3(in_funct3), .in_byte_addr(in_byte_addr), .in_wdata(in_wdata),
    .in_read(in_read), .in_write(in_write),
    .out_funct3(out_funct3), .out_byte_addr(out_byte_addr), .out_wdata(out_wdata),
    .out_read(out_read), .out_write(out_write),
    .ctl_rdata(ctl_rdata),
    .stall_o(stall_o), .ld_sel(ld_sel), .ld_data(ld_data), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  // Byte-addressed data memory behind the controller; reads return one cycle later.
  logic [7:0] mem [0:65535];
  logic       mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      mem[16'h0100] <= 8'h11; mem[16'h0101] <= 8'h22; mem[16'h0102] <= 8'h33;
      mem[16'h0103] <= 8'h44; mem[16'h0104] <= 8'h55;
      mem[16'h0003] <= 8'h80; mem[16'h0004] <= 8'hFF;
      mem[16'hFFFF] <= 8'hAA; mem[16'h0000] <= 8'hBB;
      mem[16'h0001] <= 8'hCC; mem[16'h0002] <= 8'hDD;
      for (int i = 16'h0041; i <= 16'h0044; i++) mem[i] <= 8'h5A;
    end else if (out_write) begin
      mem[out_byte_addr] <= out_wdata[7:0];
      if (out_funct3 == SH || out_funct3 == SW)
        mem[16'(out_byte_addr + 16'd1)] <= out_wdata[15:8];
      if (out_funct3 == SW) begin
        mem[16'(out_byte_addr + 16'd2)] <= out_wdata[23:16];
        mem[16'(out_byte_addr + 16'd3)] <= out_wdata[31:24];
      end
    end
  end

  always @(posedge clk) begin
    if (out_read)
      ctl_rdata <= (out_funct3 == LBU) ? {24'h0, mem[out_byte_addr]} :
                   {mem[16'(out_byte_addr + 16'd3)], mem[16'(out_byte_addr + 16'd2)],
                    mem[16'(out_byte_addr + 16'd1)], mem[out_byte_addr]};
    else
      ctl_rdata <= 32'h0;
  end

  typedef struct packed {
    bit          rd, wr, stall, mis, lsel;
    bit          care_bus, care_wd, care_ld;
    logic [2:0]  f3;
    logic [15:0] a;
    logic [31:0] wd;
    logic [31:0] ld;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          stall_total = 0;
  int          mis_total = 0;
  logic [31:0] last_ld;

  function automatic exp_t mk(input bit rd, input bit wr, input bit st, input bit mi,
                              input bit ls, input bit cb, input bit cw, input bit cl,
                              input logic [2:0] f3, input logic [15:0] a,
                              input logic [31:0] wd, input logic [31:0] ld);
    exp_t e;
    e.rd = rd; e.wr = wr; e.stall = st; e.mis = mi; e.lsel = ls;
    e.care_bus = cb; e.care_wd = cw; e.care_ld = cl;
    e.f3 = f3; e.a = a; e.wd = wd; e.ld = ld;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("out_read",   32'(out_read),   32'(cur.rd));
      chk("out_write",  32'(out_write),  32'(cur.wr));
      chk("stall_o",    32'(stall_o),    32'(cur.stall));
      chk("misalign_o", 32'(misalign_o), 32'(cur.mis));
      chk("ld_sel",     32'(ld_sel),     32'(cur.lsel));
      if (cur.care_bus) begin
        chk("out_funct3",    32'(out_funct3),    32'(cur.f3));
        chk("out_byte_addr", 32'(out_byte_addr), 32'(cur.a));
        if (cur.care_wd) chk("out_wdata", out_wdata, cur.wd);
      end
      if (cur.care_ld) chk("ld_data", ld_data, cur.ld);
    end
    if (stall_o)    stall_total++;
    if (misalign_o) mis_total++;
  end

  task automatic drive(input logic [2:0] f3, input logic [15:0] a, input logic [31:0] wd,
                       input bit rd, input bit wr);
    in_funct3 = f3; in_byte_addr = a; in_wdata = wd; in_read = rd; in_write = wr;
  endtask

  // One access followed by an idle cycle; expected bus trace built from the byte-split rules.
  task automatic access(input logic [2:0] f3, input logic [15:0] a, input logic [31:0] wd,
                        input bit rd, input bit wr, input bit chk_ld,
                        input logic [31:0] lit_ld, input int lit_stall);
    int          n, lat, cycles, s0, m0;
    bit          st, ldr, misd;
    logic [31:0] val;
    st  = wr;
    ldr = rd && !wr;
    n   = (f3 == LH || (ldr && f3 == LHU)) ? 2 : ((f3 == LW) ? 4 : 1);
    misd = (st || ldr) && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
    s0 = stall_total;
    m0 = mis_total;
    drive(f3, a, wd, rd, wr);
    if (!misd) begin
      exp_q.push_back(mk(rd, wr, 0, 0, 0, 1, 1, 1, f3, a, wd, last_ld));
      cycles = 1;
    end else begin
`ifdef MISALIGN_TRAP_EN
      exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 3'd0, 16'd0, 32'd0, last_ld));
      cycles = 1;
`else
      lat = ldr ? int'(LAT) : 0;
      val = 32'd0;
      for (int k = 0; k < n; k++) val[8*k +: 8] = mem[16'(a + 16'(k))];
      if (f3 == LH) val = {{16{val[15]}}, val[15:0]};
      for (int k = 0; k < n; k++)
        exp_q.push_back(mk(!st, st, 1, k == 0, 0, 1, st, 1, st ? SB : LBU,
                           16'(a + 16'(k)), {24'h0, wd[8*k +: 8]}, last_ld));
      for (int k = 0; k < lat; k++)
        exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 3'd0, 16'd0, 32'd0, last_ld));
      if (ldr) last_ld = val;
      exp_q.push_back(mk(0, 0, 0, 0, ldr, 0, 0, 1, 3'd0, 16'd0, 32'd0, last_ld));
      cycles = n + lat + 1;
`endif
    end
    repeat (cycles) @(posedge clk);
    #1;
    drive(3'd0, 16'd0, 32'd0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 3'd0, 16'd0, 32'd0, last_ld));
    @(posedge clk);
    #1;
    chk("stall_cycles", 32'(stall_total - s0), 32'(lit_stall));
    chk("misalign_pulses", 32'(mis_total - m0), misd ? 32'd1 : 32'd0);
    if (chk_ld) chk("ld_data_held", ld_data, lit_ld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    last_ld = 32'd0;
    drive(3'd0, 16'd0, 32'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_init = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 3'd0, 16'd0, 32'd0, 32'd0));
    @(posedge clk);
    #1;

`ifdef MISALIGN_TRAP_EN
    access(SH, 16'h0001, 32'h0000_1234, 0, 1, 0, 32'd0, 0);
    chk("mem_0001_untouched", 32'(mem[16'h0001]), 32'h0000_00CC);
    chk("mem_0002_untouched", 32'(mem[16'h0002]), 32'h0000_00DD);
    access(LW, 16'h0101, 32'd0, 1, 0, 1, 32'd0, 0);
    access(LW, 16'h0100, 32'd0, 1, 0, 0, 32'd0, 0);
`else
    access(LW,  16'h0101, 32'd0, 1, 0, 1, 32'h5544_3322, 5);
    access(LH,  16'h0003, 32'd0, 1, 0, 1, 32'hFFFF_FF80, 3);
    access(LHU, 16'h0003, 32'd0, 1, 0, 1, 32'h0000_FF80, 3);
    access(SW,  16'h0006, 32'h1234_5678, 0, 1, 1, 32'h0000_FF80, 4);
    chk("mem_0006", 32'(mem[16'h0006]), 32'h78);
    chk("mem_0007", 32'(mem[16'h0007]), 32'h56);
    chk("mem_0008", 32'(mem[16'h0008]), 32'h34);
    chk("mem_0009", 32'(mem[16'h0009]), 32'h12);
    access(LW,  16'h0008, 32'd0, 1, 0, 0, 32'd0, 0);
    access(SH,  16'h000A, 32'h0000_BEEF, 0, 1, 0, 32'd0, 0);
    chk("mem_000A", 32'(mem[16'h000A]), 32'hEF);
    chk("mem_000B", 32'(mem[16'h000B]), 32'hBE);
    // read and write both high behaves as a store
    access(SH,  16'h0011, 32'h0000_CAFE, 1, 1, 0, 32'd0, 2);
    chk("mem_0011", 32'(mem[16'h0011]), 32'hFE);
    chk("mem_0012", 32'(mem[16'h0012]), 32'hCA);
    access(LW,  16'hFFFF, 32'd0, 1, 0, 1, 32'hDDCC_BBAA, 5);

    drive(SW, 16'h0041, 32'hA1B2_C3D4, 0, 1);
    exp_q.push_back(mk(0, 1, 1, 1, 0, 1, 1, 1, SB, 16'h0041, 32'h0000_00D4, last_ld));
    exp_q.push_back(mk(0, 1, 1, 0, 0, 1, 1, 1, SB, 16'h0042, 32'h0000_00C3, last_ld));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 16'd0, 32'd0, 32'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(3'd0, 16'd0, 32'd0, 0, 0);
    last_ld = 32'd0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 3'd0, 16'd0, 32'd0, 32'd0));
    @(posedge clk);
    #1;
    chk("mem_0041", 32'(mem[16'h0041]), 32'hD4);
    chk("mem_0042", 32'(mem[16'h0042]), 32'hC3);
    chk("mem_0043", 32'(mem[16'h0043]), 32'h5A);
    chk("mem_0044", 32'(mem[16'h0044]), 32'h5A);
    access(LW, 16'h0100, 32'd0, 1, 0, 0, 32'd0, 0);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
